// File: rtl/result_grader_if.sv
// Bus between a grading harness (master) and result_grader (slave).
// GRADER_FAIL_LOG_EN adds the first-failure capture signals.
interface result_grader_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned SCORE_W = 8
);
  logic               exp_we;
  logic [IDX_W-1:0]   exp_addr;
  logic [DATA_W-1:0]  exp_data;
  logic               start;
  logic [DATA_W-1:0]  result;
  logic               result_valid;
  logic               busy;
  logic               done;
  logic [SCORE_W-1:0] score;
  logic [IDX_W:0]     pass_count;
  logic [IDX_W:0]     fail_count;
`ifdef GRADER_FAIL_LOG_EN
  logic               fail_seen;
  logic [IDX_W-1:0]   first_fail_idx;
  logic [DATA_W-1:0]  first_fail_data;
`endif

  modport master (
    output exp_we, exp_addr, exp_data, start, result, result_valid,
`ifdef GRADER_FAIL_LOG_EN
    input  fail_seen, first_fail_idx, first_fail_data,
`endif
    input  busy, done, score, pass_count, fail_count
  );

  modport slave (
    input  exp_we, exp_addr, exp_data, start, result, result_valid,
`ifdef GRADER_FAIL_LOG_EN
    output fail_seen, first_fail_idx, first_fail_data,
`endif
    output busy, done, score, pass_count, fail_count
  );
endinterface

// File: rtl/result_grader.sv
// Grades a result bus against a loadable table of expected values, one sample per valid cycle.
// Optional first-mismatch capture enabled by defining GRADER_FAIL_LOG_EN.
module result_grader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CHECKS = 20,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned POINT_WT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  result_grader_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               busy_q;
  logic               done_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   pass_q;
  logic [CNT_W-1:0]   fail_q;
  logic [DATA_W-1:0]  table_q [NUM_CHECKS];
  logic [DATA_W-1:0]  expected_c;
  logic               table_wr_c;
  logic               sample_c;
  logic               hit_c;

  assign table_wr_c = bus.exp_we && (state != RUN);
  assign sample_c   = (state == RUN) && bus.result_valid;
  assign hit_c      = (bus.result == expected_c);

  // Expectation table: only in-range addresses decode, so out-of-range writes fall away.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (table_wr_c && (bus.exp_addr == IDX_W'(i))) begin
        table_q[i] <= bus.exp_data;
      end
    end
  end

  always_comb begin
    expected_c = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (idx == IDX_W'(i)) begin
        expected_c = table_q[i];
      end
    end
  end

  // Run control and scoring; idx parks on the last entry instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      score_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            idx     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            score_q <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
          end
        end
        RUN: begin
          if (sample_c) begin
            if (hit_c) begin
              score_q <= score_q + SCORE_W'(POINT_WT);
              pass_q  <= pass_q + CNT_W'(1);
            end else begin
              fail_q  <= fail_q + CNT_W'(1);
            end
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.score      = score_q;
  assign bus.pass_count = pass_q;
  assign bus.fail_count = fail_q;

`ifdef GRADER_FAIL_LOG_EN
  logic               fail_seen_q;
  logic [IDX_W-1:0]   first_fail_idx_q;
  logic [DATA_W-1:0]  first_fail_data_q;

  // Keep only the first mismatch of each run.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_seen_q       <= 1'b0;
      first_fail_idx_q  <= '0;
      first_fail_data_q <= '0;
    end else if ((state != RUN) && bus.start) begin
      fail_seen_q       <= 1'b0;
      first_fail_idx_q  <= '0;
      first_fail_data_q <= '0;
    end else if (sample_c && !hit_c && !fail_seen_q) begin
      fail_seen_q       <= 1'b1;
      first_fail_idx_q  <= idx;
      first_fail_data_q <= bus.result;
    end
  end

  assign bus.fail_seen       = fail_seen_q;
  assign bus.first_fail_idx  = first_fail_idx_q;
  assign bus.first_fail_data = first_fail_data_q;
`endif

endmodule

// File: tb/tb_result_grader.sv
// Directed bench for result_grader: a sample-list model checked every cycle, plus literal pins.
// Two instances share stimulus so point weights 1 and 3 are graded side by side.
module tb_result_grader;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_we;
  logic [IW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          start;
  logic [DW-1:0] result;
  logic          result_valid;

  always #5 clk = ~clk;

  result_grader_if #(.DATA_W(DW), .IDX_W(IW), .SCORE_W(SW)) bus1 ();
  result_grader_if #(.DATA_W(DW), .IDX_W(IW), .SCORE_W(SW)) bus3 ();

  assign bus1.exp_we = exp_we;   assign bus3.exp_we = exp_we;
  assign bus1.exp_addr = exp_addr; assign bus3.exp_addr = exp_addr;
  assign bus1.exp_data = exp_data; assign bus3.exp_data = exp_data;
  assign bus1.start = start;     assign bus3.start = start;
  assign bus1.result = result;   assign bus3.result = result;
  assign bus1.result_valid = result_valid; assign bus3.result_valid = result_valid;

  result_grader #(.DATA_W(DW), .NUM_CHECKS(N), .IDX_W(IW), .SCORE_W(SW), .POINT_WT(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  result_grader #(.DATA_W(DW), .NUM_CHECKS(N), .IDX_W(IW), .SCORE_W(SW), .POINT_WT(3))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model: a run is "take N valid samples, count those equal to the table entry"
  logic [DW-1:0] m_tab [8];
  bit            m_run, m_done, m_fs;
  int            m_n, m_pass, m_fail, m_fi;
  logic [DW-1:0] m_fd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear_run();
    m_n = 0; m_pass = 0; m_fail = 0; m_fs = 1'b0; m_fi = 0; m_fd = '0;
  endtask

  task automatic model_edge();
    bit was_run;
    was_run = m_run;
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0;
      model_clear_run();
    end else begin
      if (exp_we && !was_run && (exp_addr < IW'(N))) m_tab[exp_addr] = exp_data;
      if (was_run) begin
        if (result_valid) begin
          if (result == m_tab[m_n[IW-1:0]]) m_pass++;
          else begin
            m_fail++;
            if (!m_fs) begin m_fs = 1'b1; m_fi = m_n; m_fd = result; end
          end
          m_n++;
          if (m_n == int'(N)) begin m_run = 1'b0; m_done = 1'b1; end
        end
      end else if (start) begin
        m_run = 1'b1; m_done = 1'b0;
        model_clear_run();
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(bus1.busy), 64'(m_run));
      chk("done", 64'(bus1.done), 64'(m_done));
      chk("score_w1", 64'(bus1.score), 64'(m_pass));
      chk("score_w3", 64'(bus3.score), 64'(m_pass * 3));
      chk("pass_count", 64'(bus1.pass_count), 64'(m_pass));
      chk("fail_count", 64'(bus1.fail_count), 64'(m_fail));
      chk("fail_count_w3", 64'(bus3.fail_count), 64'(m_fail));
`ifdef GRADER_FAIL_LOG_EN
      chk("fail_seen", 64'(bus1.fail_seen), 64'(m_fs));
      chk("first_fail_idx", 64'(bus1.first_fail_idx), 64'(m_fi));
      chk("first_fail_data", 64'(bus1.first_fail_data), 64'(m_fd));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit we, input int addr, input int data, input bit st,
                     input int res, input bit vld);
    exp_we = we; exp_addr = IW'(addr); exp_data = DW'(data);
    start = st; result = DW'(res); result_valid = vld;
    step();
  endtask

  task automatic wr(input int a, input int d);  cyc(1'b1, a, d, 1'b0, 0, 1'b0); endtask
  task automatic go();                          cyc(1'b0, 0, 0, 1'b1, 0, 1'b0); endtask
  task automatic smp(input int r);              cyc(1'b0, 0, 0, 1'b0, r, 1'b1); endtask
  task automatic gap();                         cyc(1'b0, 0, 0, 1'b0, 0, 1'b0); endtask

  task automatic run4(input int a, input int b, input int c, input int d);
    smp(a); smp(b); smp(c); smp(d);
  endtask

  initial begin
    reset = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    start = 1'b0; result = '0; result_valid = 1'b0;
    step();
    check_en = 1'b1;
    step();
    chk("lit_reset_score", 64'(bus1.score), 64'd0);
    chk("lit_reset_busy", 64'(bus1.busy), 64'd0);
    chk("lit_reset_done", 64'(bus1.done), 64'd0);
    reset = 1'b0;

    wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 4); wr(5, 99);

    // all hits
    go();
    chk("lit_run_busy", 64'(bus1.busy), 64'd1);
    run4(0, 1, 2, 4);
    chk("lit_t1_done", 64'(bus1.done), 64'd1);
    chk("lit_t1_busy", 64'(bus1.busy), 64'd0);
    chk("lit_t1_score", 64'(bus1.score), 64'd4);
    chk("lit_t1_score_w3", 64'(bus3.score), 64'd12);
    chk("lit_t1_fail", 64'(bus1.fail_count), 64'd0);
    smp(0);
    chk("lit_after_done_score", 64'(bus1.score), 64'd4);

    // one miss, then two misses
    go(); run4(0, 1, 7, 4);
    chk("lit_t2_score", 64'(bus1.score), 64'd3);
    chk("lit_t2_fail", 64'(bus1.fail_count), 64'd1);
`ifdef GRADER_FAIL_LOG_EN
    chk("lit_t2_ffidx", 64'(bus1.first_fail_idx), 64'd2);
    chk("lit_t2_ffdata", 64'(bus1.first_fail_data), 64'd7);
`endif
    go();
    chk("lit_t2b_cleared", 64'(bus1.score), 64'd0);
    run4(0, 9, 8, 4);
    chk("lit_t2b_fail", 64'(bus1.fail_count), 64'd2);
`ifdef GRADER_FAIL_LOG_EN
    chk("lit_t2b_ffidx", 64'(bus1.first_fail_idx), 64'd1);
    chk("lit_t2b_ffdata", 64'(bus1.first_fail_data), 64'd9);
`endif

    // valid gaps
    go(); smp(0); gap(); gap(); gap();
    chk("lit_t3_pass_gap", 64'(bus1.pass_count), 64'd1);
    chk("lit_t3_busy_gap", 64'(bus1.busy), 64'd1);
    smp(1); smp(2);
    chk("lit_t3_done_early", 64'(bus1.done), 64'd0);
    smp(4);
    chk("lit_t3_done", 64'(bus1.done), 64'd1);
    chk("lit_t3_score", 64'(bus1.score), 64'd4);

    // reset mid-run keeps the table
    go(); smp(0); smp(1);
    reset = 1'b1; gap(); reset = 1'b0;
    chk("lit_t4_score", 64'(bus1.score), 64'd0);
    chk("lit_t4_busy", 64'(bus1.busy), 64'd0);
    go(); run4(0, 1, 2, 4);
    chk("lit_t4_rerun", 64'(bus1.score), 64'd4);

    // start and write during RUN are dropped
    go();
    cyc(1'b1, 0, 9, 1'b1, 0, 1'b1);
    smp(1); smp(2); smp(4);
    chk("lit_t5_score", 64'(bus1.score), 64'd4);
    go(); run4(0, 1, 2, 4);
    chk("lit_t5_table_kept", 64'(bus1.score), 64'd4);

    // restart from DONE with a same-edge table write
    go(); run4(0, 1, 7, 4);
    chk("lit_t6_first", 64'(bus1.score), 64'd3);
    cyc(1'b1, 3, 5, 1'b1, 0, 1'b0);
    chk("lit_t6_cleared_fail", 64'(bus1.fail_count), 64'd0);
    run4(0, 1, 2, 5);
    chk("lit_t6_score", 64'(bus1.score), 64'd4);
    chk("lit_t6_score_w3", 64'(bus3.score), 64'd12);
    gap(); gap();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
